// File: rtl/norm_stream_sink.sv
// Terminating sink for the normalization stage: joint sample/tag beats, tag continuity check,
// warm-up discard and a pop-read FIFO. Define NORM_SINK_CLIP_EN to saturate stored samples.
module norm_stream_sink #(
  parameter int                 DEPTH      = 16,
  parameter int                 WARMUP     = 8,
  parameter logic signed [31:0] CLIP_LIMIT = 32'sh0000_4000
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              s_axis_data_tdata,
  input  logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tready,
  input  logic [7:0]               s_axis_config_tdata,
  input  logic                     s_axis_config_tvalid,
  output logic                     s_axis_config_tready,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic [4:0]               rd_tag,
  output logic                     rd_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     seq_err,
  output logic                     overflow,
  output logic [15:0]              clip_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("norm_stream_sink: DEPTH must be a power of two in 4..256");
  end
  if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warmup
    $error("norm_stream_sink: WARMUP must be in 0..255");
  end
  if (CLIP_LIMIT <= 0) begin : g_bad_clip
    $error("norm_stream_sink: CLIP_LIMIT must be positive");
  end

  logic [36:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          tready_q;
  logic [7:0]    warm_q;
  logic          exp_valid_q;
  logic [4:0]    exp_tag_q;
  logic          seq_err_q, overflow_q;
  logic [15:0]   clip_cnt_q;
  logic [31:0]   rd_data_q;
  logic [4:0]    rd_tag_q;
  logic          rd_valid_q;

  logic        full, fire, store, pop, both_valid;
  logic [31:0] sample_st;
  logic        clip_hit;
  logic        unused_tag_hi;

  assign unused_tag_hi = ^s_axis_config_tdata[7:5];

  // Handshake: a beat fires only when both channels are valid and the shared ready is high.
  assign both_valid = s_axis_data_tvalid & s_axis_config_tvalid;
  assign full       = (level_q == LW'(DEPTH));
  assign fire       = both_valid & tready_q & ~clear;
  assign store      = fire & (warm_q == 8'd0);
  assign pop        = rd_en & (level_q != '0) & ~clear;

`ifdef NORM_SINK_CLIP_EN
  always_comb begin
    sample_st = s_axis_data_tdata;
    clip_hit  = 1'b0;
    if ($signed(s_axis_data_tdata) > CLIP_LIMIT) begin
      sample_st = CLIP_LIMIT;
      clip_hit  = 1'b1;
    end else if ($signed(s_axis_data_tdata) < -CLIP_LIMIT) begin
      sample_st = -CLIP_LIMIT;
      clip_hit  = 1'b1;
    end
  end
`else
  assign sample_st = s_axis_data_tdata;
  assign clip_hit  = 1'b0;
`endif

  always_comb begin
    level_d = level_q;
    if (store && !pop) level_d = level_q + LW'(1);
    else if (pop && !store) level_d = level_q - LW'(1);
  end

  always_ff @(posedge aclk) begin
    if (store) mem_q[wr_ptr_q] <= {s_axis_config_tdata[4:0], sample_st};
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tready_q    <= 1'b0;
      warm_q      <= 8'(WARMUP);
      exp_valid_q <= 1'b0;
      exp_tag_q   <= '0;
      seq_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
      clip_cnt_q  <= '0;
      rd_data_q   <= '0;
      rd_tag_q    <= '0;
      rd_valid_q  <= 1'b0;
    end else if (clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tready_q    <= 1'b0;
      warm_q      <= 8'(WARMUP);
      exp_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
      clip_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      level_q    <= level_d;
      // Ready follows the next level, so a pop while full reopens the sink one cycle later.
      tready_q   <= (level_d != LW'(DEPTH));
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= mem_q[rd_ptr_q][31:0];
        rd_tag_q  <= mem_q[rd_ptr_q][36:32];
        rd_ptr_q  <= rd_ptr_q + PW'(1);
      end
      if (store) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (store && clip_hit && clip_cnt_q != 16'hFFFF) clip_cnt_q <= clip_cnt_q + 16'd1;
      if (fire) begin
        if (warm_q != 8'd0) warm_q <= warm_q - 8'd1;
        if (exp_valid_q && s_axis_config_tdata[4:0] != exp_tag_q) seq_err_q <= 1'b1;
        exp_tag_q   <= s_axis_config_tdata[4:0] + 5'd1;
        exp_valid_q <= 1'b1;
      end
      if (both_valid && full) overflow_q <= 1'b1;
    end
  end

  assign s_axis_data_tready   = tready_q;
  assign s_axis_config_tready = tready_q;
  assign rd_data              = rd_data_q;
  assign rd_tag               = rd_tag_q;
  assign rd_valid             = rd_valid_q;
  assign empty                = (level_q == '0);
  assign level                = level_q;
  assign seq_err              = seq_err_q;
  assign overflow             = overflow_q;
  assign clip_cnt             = clip_cnt_q;

endmodule

// File: tb/tb_norm_stream_sink.sv
// Directed bench for norm_stream_sink (DEPTH=16, WARMUP=8); checks follow the
// NORM_SINK_CLIP_EN setting of the build.
module tb_norm_stream_sink;

  localparam int WARMUP = 8;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] d_tdata;
  logic        d_tvalid;
  logic        d_tready;
  logic [7:0]  c_tdata;
  logic        c_tvalid;
  logic        c_tready;
  logic        clear;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [4:0]  rd_tag;
  logic        rd_valid;
  logic        empty;
  logic [4:0]  level;
  logic        seq_err;
  logic        overflow;
  logic [15:0] clip_cnt;

  int vectors = 0;
  int errors  = 0;
  int warm_m;
  logic [36:0] exp_q[$];

  always #5 aclk = ~aclk;

  norm_stream_sink dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_data_tdata    (d_tdata),
    .s_axis_data_tvalid   (d_tvalid),
    .s_axis_data_tready   (d_tready),
    .s_axis_config_tdata  (c_tdata),
    .s_axis_config_tvalid (c_tvalid),
    .s_axis_config_tready (c_tready),
    .clear                (clear),
    .rd_en                (rd_en),
    .rd_data              (rd_data),
    .rd_tag               (rd_tag),
    .rd_valid             (rd_valid),
    .empty                (empty),
    .level                (level),
    .seq_err              (seq_err),
    .overflow             (overflow),
    .clip_cnt             (clip_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [7:0] tag, input logic [31:0] data);
    int n;
    n = 0;
    d_tdata = data; c_tdata = tag; d_tvalid = 1'b1; c_tvalid = 1'b1;
    while (!d_tready && n < 40) begin
      @(posedge aclk); #1; n++;
    end
    vectors++;
    if (n >= 40) begin errors++; $display("FAIL beat_timeout tag=%0d tready=%0b required=1", tag, d_tready); end
    @(posedge aclk); #1;
    d_tvalid = 1'b0; c_tvalid = 1'b0;
    if (warm_m > 0) warm_m--;
    else exp_q.push_back({tag[4:0], data});
  endtask

  task automatic pop_check(input string name);
    logic [36:0] e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    rd_en = 1'b1;
    @(posedge aclk); #1;
    rd_en = 1'b0;
    vectors++;
    if (rd_valid !== 1'b1 || {rd_tag, rd_data} !== e)
      begin errors++; $display("FAIL %s got valid=%0b tag=%0d data=%0h required tag=%0d data=%0h",
                               name, rd_valid, rd_tag, rd_data, e[36:32], e[31:0]); end
  endtask

  task automatic do_clear(input logic with_beat, input logic [7:0] tag);
    clear = 1'b1;
    if (with_beat) begin d_tvalid = 1'b1; c_tvalid = 1'b1; c_tdata = tag; d_tdata = 32'hDEAD; end
    @(posedge aclk); #1;
    clear = 1'b0; d_tvalid = 1'b0; c_tvalid = 1'b0;
    warm_m = WARMUP;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got=%0d required=0", level); end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%0b required=1", empty); end
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%0b required=0", rd_valid); end
    vectors++; if (rd_data !== 32'd0 || rd_tag !== 5'd0) begin errors++; $display("FAIL rst_rd got=%0h/%0h required=0/0", rd_data, rd_tag); end
    vectors++; if (seq_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_flags got=%0b%0b required=00", seq_err, overflow); end
    vectors++; if (clip_cnt !== 16'd0) begin errors++; $display("FAIL rst_clip got=%0d required=0", clip_cnt); end
    vectors++; if (d_tready !== 1'b0 || c_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got=%0b%0b required=00", d_tready, c_tready); end
    aresetn = 1'b0;
    @(posedge aclk); #1;
    vectors++; if (d_tready !== 1'b1 || c_tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready got=%0b%0b required=11", d_tready, c_tready); end
  endtask

  task automatic test_warmup();
    for (int i = 0; i < 12; i++) send_beat(8'(i), 32'(100 + i));
    vectors++; if (level !== 5'd4) begin errors++; $display("FAIL warmup_level got=%0d required=4", level); end
    vectors++; if (seq_err !== 1'b0) begin errors++; $display("FAIL warmup_seq_err got=%0b required=0", seq_err); end
    for (int i = 0; i < 4; i++) pop_check("warmup_pop");
    @(posedge aclk); #1;
    vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got=%0b required=0", rd_valid); end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL warmup_empty got=%0b required=1", empty); end
  endtask

  task automatic test_tag_wrap_clear();
    do_clear(1'b0, 8'd0);
    @(posedge aclk); #1;
    send_beat(8'd30, 32'd1); send_beat(8'd31, 32'd2); send_beat(8'd0, 32'd3); send_beat(8'd1, 32'd4);
    vectors++; if (seq_err !== 1'b0) begin errors++; $display("FAIL wrap_no_err got=%0b required=0", seq_err); end
    send_beat(8'd3, 32'd5);
    vectors++; if (seq_err !== 1'b1) begin errors++; $display("FAIL skip_err got=%0b required=1", seq_err); end
    send_beat(8'd4, 32'd6);
    vectors++; if (seq_err !== 1'b1) begin errors++; $display("FAIL skip_sticky got=%0b required=1", seq_err); end
    vectors++; if (level !== 5'd0) begin errors++; $display("FAIL warm_not_stored got=%0d required=0", level); end
    for (int t = 5; t <= 12; t++) send_beat(8'(t), 32'(t));
    vectors++; if (level !== 5'd6) begin errors++; $display("FAIL pre_clear_level got=%0d required=6", level); end
    do_clear(1'b1, 8'd13);
    vectors++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL clear_level got=%0d/%0b required=0/1", level, empty); end
    vectors++; if (seq_err !== 1'b0) begin errors++; $display("FAIL clear_seq_err got=%0b required=0", seq_err); end
    vectors++; if (d_tready !== 1'b0) begin errors++; $display("FAIL clear_tready got=%0b required=0", d_tready); end
    @(posedge aclk); #1;
    vectors++; if (d_tready !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL post_clear got tready=%0b level=%0d required 1/0", d_tready, level); end
    send_beat(8'd20, 32'd7);
    vectors++; if (seq_err !== 1'b0) begin errors++; $display("FAIL clear_exp_invalid got=%0b required=0", seq_err); end
  endtask

  task automatic test_full();
    do_clear(1'b0, 8'd0);
    @(posedge aclk); #1;
    for (int t = 0; t < 24; t++) send_beat(8'(t), 32'h1000 + 32'(t));
    vectors++; if (level !== 5'd16 || d_tready !== 1'b0) begin errors++; $display("FAIL full got level=%0d tready=%0b required 16/0", level, d_tready); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf got=%0b required=0", overflow); end
    d_tdata = 32'h1018; c_tdata = 8'd24; d_tvalid = 1'b1; c_tvalid = 1'b1;
    repeat (2) begin @(posedge aclk); #1; end
    vectors++; if (overflow !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL overflow got ovf=%0b level=%0d required 1/16", overflow, level); end
    rd_en = 1'b1;
    @(posedge aclk); #1;
    rd_en = 1'b0;
    void'(exp_q.pop_front());
    vectors++; if (level !== 5'd15 || d_tready !== 1'b1) begin errors++; $display("FAIL pop_full got level=%0d tready=%0b required 15/1", level, d_tready); end
    vectors++; if (rd_valid !== 1'b1 || rd_tag !== 5'd8 || rd_data !== 32'h1008) begin errors++; $display("FAIL pop_full_data got %0b/%0d/%0h required 1/8/1008", rd_valid, rd_tag, rd_data); end
    @(posedge aclk); #1;
    d_tvalid = 1'b0; c_tvalid = 1'b0;
    exp_q.push_back({5'd24, 32'h1018});
    vectors++; if (level !== 5'd16 || d_tready !== 1'b0) begin errors++; $display("FAIL held_beat got level=%0d tready=%0b required 16/0", level, d_tready); end
    for (int i = 0; i < 16; i++) pop_check("full_drain");
    vectors++; if (empty !== 1'b1 || seq_err !== 1'b0) begin errors++; $display("FAIL full_end got empty=%0b seq=%0b required 1/0", empty, seq_err); end
  endtask

  task automatic test_half_valid();
    d_tdata = 32'hABC; c_tdata = 8'd25; d_tvalid = 1'b1; c_tvalid = 1'b0;
    repeat (5) begin @(posedge aclk); #1; end
    vectors++; if (level !== 5'd0) begin errors++; $display("FAIL half_valid_hold got=%0d required=0", level); end
    c_tvalid = 1'b1;
    @(posedge aclk); #1;
    d_tvalid = 1'b0; c_tvalid = 1'b0;
    exp_q.push_back({5'd25, 32'hABC});
    vectors++; if (level !== 5'd1) begin errors++; $display("FAIL half_valid_store got=%0d required=1", level); end
    pop_check("half_valid_pop");
  endtask

  task automatic test_empty_read();
    @(posedge aclk); #1;
    rd_en = 1'b1;
    @(posedge aclk); #1;
    rd_en = 1'b0;
    vectors++; if (rd_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL empty_read got valid=%0b level=%0d required 0/0", rd_valid, level); end
    vectors++; if (overflow !== 1'b1 || seq_err !== 1'b0) begin errors++; $display("FAIL empty_read_flags got ovf=%0b seq=%0b required 1/0", overflow, seq_err); end
  endtask

  task automatic test_back_to_back();
    send_beat(8'd26, 32'h2626);
    d_tdata = 32'h2727; c_tdata = 8'd27; d_tvalid = 1'b1; c_tvalid = 1'b1; rd_en = 1'b1;
    @(posedge aclk); #1;
    d_tvalid = 1'b0; c_tvalid = 1'b0; rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({5'd27, 32'h2727});
    vectors++; if (level !== 5'd1) begin errors++; $display("FAIL wr_pop_level got=%0d required=1", level); end
    vectors++; if (rd_valid !== 1'b1 || rd_tag !== 5'd26 || rd_data !== 32'h2626) begin errors++; $display("FAIL wr_pop_data got %0b/%0d/%0h required 1/26/2626", rd_valid, rd_tag, rd_data); end
    pop_check("wr_pop_second");
  endtask

  task automatic test_clip();
    logic [15:0] exp_cnt;
    logic [31:0] e0, e1, e2;
`ifdef NORM_SINK_CLIP_EN
    exp_cnt = 16'd2; e0 = 32'h0000_4000; e1 = 32'hFFFF_C000; e2 = 32'h0000_0100;
`else
    exp_cnt = 16'd0; e0 = 32'h0000_5000; e1 = 32'hFFFF_A000; e2 = 32'h0000_0100;
`endif
    do_clear(1'b0, 8'd0);
    vectors++; if (overflow !== 1'b0 || clip_cnt !== 16'd0) begin errors++; $display("FAIL clear_ovf got ovf=%0b clip=%0d required 0/0", overflow, clip_cnt); end
    @(posedge aclk); #1;
    for (int t = 0; t < 8; t++) send_beat(8'(t), 32'h7000_0000);
    send_beat(8'd8, 32'h0000_5000); send_beat(8'd9, 32'hFFFF_A000); send_beat(8'd10, 32'h0000_0100);
    exp_q.delete();
    exp_q.push_back({5'd8, e0}); exp_q.push_back({5'd9, e1}); exp_q.push_back({5'd10, e2});
    vectors++; if (clip_cnt !== exp_cnt || level !== 5'd3) begin errors++; $display("FAIL clip_cnt got=%0d level=%0d required %0d/3", clip_cnt, level, exp_cnt); end
    for (int i = 0; i < 3; i++) pop_check("clip_pop");
  endtask

  task automatic test_async_reset();
    send_beat(8'd11, 32'h11); send_beat(8'd12, 32'h12);
    vectors++; if (level !== 5'd2) begin errors++; $display("FAIL pre_reset_level got=%0d required=2", level); end
    d_tdata = 32'h13; c_tdata = 8'd13; d_tvalid = 1'b1; c_tvalid = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    vectors++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL async_level got=%0d/%0b required 0/1", level, empty); end
    vectors++; if (d_tready !== 1'b0 || c_tready !== 1'b0) begin errors++; $display("FAIL async_tready got=%0b%0b required=00", d_tready, c_tready); end
    vectors++; if (rd_data !== 32'd0 || rd_tag !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL async_rd got %0h/%0d/%0b required 0/0/0", rd_data, rd_tag, rd_valid); end
    vectors++; if (seq_err !== 1'b0 || overflow !== 1'b0 || clip_cnt !== 16'd0) begin errors++; $display("FAIL async_flags got %0b/%0b/%0d required 0/0/0", seq_err, overflow, clip_cnt); end
    d_tvalid = 1'b0; c_tvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    vectors++; if (d_tready !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL async_release got tready=%0b level=%0d required 1/0", d_tready, level); end
    warm_m = WARMUP;
    exp_q.delete();
  endtask

  initial begin
    aresetn = 1'b1; d_tdata = '0; d_tvalid = 1'b0; c_tdata = '0; c_tvalid = 1'b0;
    clear = 1'b0; rd_en = 1'b0; warm_m = WARMUP;
    repeat (2) @(posedge aclk);
    #1;
    test_reset();
    test_warmup();
    test_tag_wrap_clear();
    test_full();
    test_half_valid();
    test_empty_read();
    test_back_to_back();
    test_clip();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/norm_stream_sink.md
Name: norm_stream_sink

Overview:
- Terminating receiver for the normalization stage's output.
- Consumes the 32-bit normalized-sample AXI-Stream together with the 8-bit config/tag AXI-Stream as one joint beat.
- Checks tag sequence continuity, discards a programmable warm-up prefix and buffers {tag, sample} pairs in a FIFO.
- A simple pop-style read port lets the AIRISC peripheral wrapper drain the FIFO.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..256
WARMUP, 8, accepted beats discarded after reset/clear, 0..255
CLIP_LIMIT, 32'sh0000_4000, symmetric clip magnitude (Q.FXP), used only with NORM_SINK_CLIP_EN

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-high reset (despite the name, asserted = 1)
s_axis_data_tdata  in  32  signed normalized sample
s_axis_data_tvalid  in  1  sample valid
s_axis_data_tready  out  1  sample ready
s_axis_config_tdata  in  8  tag; bits [4:0] = 5-bit sample counter, [7:5] ignored
s_axis_config_tvalid  in  1  tag valid
s_axis_config_tready  out  1  tag ready
clear  in  1  synchronous flush
rd_en  in  1  pop request
rd_data  out  32  popped sample
rd_tag  out  5  popped tag
rd_valid  out  1  rd_data/rd_tag valid (one-cycle pulse)
empty  out  1  FIFO empty
level  out  $clog2(DEPTH)+1  entries stored
seq_err  out  1  sticky, set on tag discontinuity
overflow  out  1  sticky, set on attempted beat while full
clip_cnt  out  16  clipped-sample count; constant 0 without the macro

Behaviour:
- Reset (async, aresetn=1): FIFO empty, level=0, rd_valid=0, rd_data=0, rd_tag=0, seq_err=0, overflow=0, clip_cnt=0, warm-up counter=WARMUP, expected-tag register invalid.
- Readiness: s_axis_data_tready = s_axis_config_tready = !full.
  - Both readies are registered from the next-state level and never depend on either tvalid.
- Joint beat: fires only when both tvalids and both treadys are 1 in the same cycle.
  - If only one tvalid is high, nothing is consumed and that channel's payload is held by the source.
- Tag check on every fired beat:
  - First beat after reset/clear loads the expected tag = tag+1 (mod 32).
  - Each later beat compares the tag against the expected tag. On mismatch, set seq_err and resync expected = tag+1.
  - Tag wraps 31->0 legally.
- Warm-up: while the warm-up counter is >0, a fired beat is consumed, tag-checked and the counter decremented, but the beat is not stored.
- Store: otherwise write {tag[4:0], sample} at the write pointer in the same edge.
  - Latency from beat to empty=0 is 1 cycle.
- Overflow: both tvalids high while full (so tready=0) sets overflow. No data is lost at the sink, because the source stalls.
- Read:
  - rd_en with !empty pops the head entry; rd_data/rd_tag register it and rd_valid=1 on the next cycle.
  - rd_en while empty is ignored, rd_valid stays 0 and no flag is set.
- Simultaneous write and pop:
  - Level stays unchanged.
  - When full, the write is still blocked that cycle because tready was already 0; tready rises the following cycle.
- Pointers wrap modulo DEPTH. full = (level==DEPTH).
- clear (synchronous; aresetn has priority):
  - Empties the FIFO and clears seq_err, overflow and clip_cnt.
  - Reloads the warm-up counter and invalidates the expected tag.
  - A beat presented in the clear cycle is dropped, and tready is 0 in the cycle following clear.
- Reset mid-stream: all state is lost immediately; tready=0 while reset is asserted.

Optional Feature:
NORM_SINK_CLIP_EN
- Defined: the sample is saturated to [-CLIP_LIMIT, +CLIP_LIMIT] before storing. Each stored clipped sample increments clip_cnt, which saturates at 16'hFFFF. Discarded warm-up beats are neither clipped nor counted.
- Undefined: samples are stored unchanged and clip_cnt is tied to 0.

Test Plan:
- Warm-up: WARMUP=8; stream 12 beats with tags 0..11 and data 100..111 -> level=4; pops return (8,108)..(11,111); seq_err=0.
- Tag wrap and skip: tags 30,31,0,1 then 3 -> seq_err=1 only after tag 3; a following tag 4 gives no further change.
- Full/backpressure: DEPTH=16, WARMUP=0, no reads, 20 beats offered -> tready drops after 16 stores; overflow=1; the source holds beat 17, and after one pop beat 17 is stored on the cycle after tready rises.
- Half-valid: data_tvalid=1, config_tvalid=0 for 5 cycles, then both high -> exactly one entry stored; level=1.
- Clear and reset: clear with level=6 and seq_err=1 -> next cycle level=0, empty=1, seq_err=0; aresetn pulsed mid-burst -> all outputs at reset values asynchronously.
- Clip (macro on, CLIP_LIMIT=0x4000): samples 0x5000, -0x6000, 0x100 -> stored 0x4000, -0x4000, 0x100; clip_cnt=2.
